mac_golden_checker: RTL and testbench

Parametrised, synthesizable golden-model scoreboard for the MAC cluster. It computes expected outputs for single, dual and quad grouping modes, with or without accumulation, for any lane count and width. Expected values pass through a delay line matched to DUT latency and are compared against the DUT outputs. A run-control FSM counts checked samples, captures the first mismatch and reports pass or fail. It replaces free-running simulation-only golden logic in bench tops and also sits beside the cluster in FPGA bring-up.

---
 rtl/mac_golden_checker_if.sv | 13 +
 rtl/mac_golden_checker.sv | 140 ++++++++++++++
 tb/tb_mac_golden_checker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_golden_checker_if.sv
// mac_golden_checker_if: operand/result bus between the MAC cluster side and the golden checker
interface mac_golden_checker_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
);
  logic                   in_valid;
  logic [LANES*IN_W-1:0]  a;
  logic [LANES*IN_W-1:0]  b;
  logic [LANES*ACC_W-1:0] dut_out;
  modport master (output in_valid, a, b, dut_out);
  modport slave  (input  in_valid, a, b, dut_out);
endinterface

// File: rtl/mac_golden_checker.sv
// mac_golden_checker: golden MAC model with latency-matched compare, run-control FSM and first-error capture
module mac_golden_checker #(
  parameter int LANES   = 4,
  parameter int IN_W    = 8,
  parameter int ACC_W   = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 32,
  localparam int LW     = $clog2(LANES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_tests,
  input  logic                   stop_on_err,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_acc,
  input  logic [LANES*ACC_W-1:0] init_acc,
  mac_golden_checker_if.slave    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       checked,
  output logic [CNT_W-1:0]       first_err_idx,
  output logic [LW-1:0]          first_err_lane,
  output logic [ACC_W-1:0]       first_err_exp,
  output logic [ACC_W-1:0]       first_err_got
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  state_t                 state, state_n;
  logic [1:0]             mode_r, mode_eff;
  logic                   acc_r, stop_r;
  logic [CNT_W-1:0]       num_r, checked_n, err_n;
  logic [LANES*ACC_W-1:0] acc, gold;
  logic [LANES*ACC_W-1:0] gv [3];
  logic [LANES*ACC_W-1:0] dl [LATENCY];
  logic [LATENCY-1:0]     dv;
  logic [LANES-1:0]       lane_bad;
  logic                   do_cmp, bad, keep;
  logic [LW-1:0]          bad_lane;
  logic [ACC_W-1:0]       bad_exp, bad_got;
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int G = 1 << m;
    localparam int W = G * ACC_W;
    logic [LANES*ACC_W-1:0] v;
    if (G <= LANES) begin : g_on
      for (genvar k = 0; k < LANES / G; k++) begin : g_grp
        logic [W-1:0] pa, pb, pc;
        assign pa = W'(bus.a[k*G*IN_W +: G*IN_W]);
        assign pb = W'(bus.b[k*G*IN_W +: G*IN_W]);
        assign pc = acc_r ? acc[k*W +: W] : '0;
        assign v[k*W +: W] = pa * pb + pc;
      end
    end else begin : g_off
      assign v = '0;
    end
    assign gv[m] = v;
  end
  // reserved mode and groups wider than the cluster fall back to single-lane grouping
  assign mode_eff  = (mode_r == 2'd1 && LANES >= 2) ? 2'd1 : (mode_r == 2'd2 && LANES >= 4) ? 2'd2 : 2'd0;
  assign gold      = mode_eff == 2'd1 ? gv[1] : mode_eff == 2'd2 ? gv[2] : gv[0];
  for (genvar k = 0; k < LANES; k++) begin : g_cmp
    assign lane_bad[k] = dl[LATENCY-1][k*ACC_W +: ACC_W] != bus.dut_out[k*ACC_W +: ACC_W];
  end
  assign do_cmp    = state == RUN && dv[LATENCY-1] && checked < num_r;
  assign bad       = do_cmp && |lane_bad;
  assign checked_n = checked + CNT_W'(do_cmp);
  assign err_n     = (bad && !(&err_count)) ? err_count + 1'b1 : err_count;
  assign state_n   = state == RUN ? ((bad && stop_r) ? FAIL : (checked_n == num_r) ? DONE : RUN)
                                  : (start ? RUN : state);
  assign keep      = state == RUN && state_n == RUN;
  always_comb begin
    bad_lane = '0;
    bad_exp  = '0;
    bad_got  = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (lane_bad[i]) begin
        bad_lane = LW'(i);
        bad_exp  = dl[LATENCY-1][i*ACC_W +: ACC_W];
        bad_got  = bus.dut_out[i*ACC_W +: ACC_W];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mode_r         <= '0;
      acc_r          <= 1'b0;
      stop_r         <= 1'b0;
      num_r          <= '0;
      acc            <= '0;
      dv             <= '0;
      checked        <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_lane <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
      for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
    end else begin
      state <= state_n;
      busy  <= state_n == RUN;
      done  <= state_n == DONE || state_n == FAIL;
      if (state != RUN && start) begin
        mode_r         <= cfg_mode;
        acc_r          <= cfg_acc;
        stop_r         <= stop_on_err;
        num_r          <= num_tests;
        acc            <= init_acc;
        pass           <= 1'b0;
        checked        <= '0;
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_lane <= '0;
        first_err_exp  <= '0;
        first_err_got  <= '0;
      end else if (state == RUN) begin
        checked   <= checked_n;
        err_count <= err_n;
        pass      <= state_n == DONE && err_n == '0;
        if (bus.in_valid) acc <= gold;
        if (bad && err_count == '0) begin
          first_err_idx  <= checked;
          first_err_lane <= bad_lane;
          first_err_exp  <= bad_exp;
          first_err_got  <= bad_got;
        end
      end
      // anything still in flight when the run ends is dropped
      dv[0] <= keep && bus.in_valid;
      dl[0] <= gold;
      for (int i = 1; i < LATENCY; i++) begin
        dv[i] <= keep && dv[i-1];
        dl[i] <= dl[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mac_golden_checker.sv
// tb_mac_golden_checker: randomized and directed runs scored against a concatenated-arithmetic reference model
module tb_mac_golden_checker;
  localparam int LANES = 4, IN_W = 8, ACC_W = 32, LATENCY = 2, CNT_W = 32;
  localparam int LW = $clog2(LANES) + 1;
  logic                   clk = 1'b0;
  logic                   rst, start, stop_on_err, cfg_acc;
  logic [1:0]             cfg_mode;
  logic [CNT_W-1:0]       num_tests;
  logic [LANES*ACC_W-1:0] init_acc;
  logic                   busy, done, pass;
  logic [CNT_W-1:0]       err_count, checked, first_err_idx;
  logic [LW-1:0]          first_err_lane;
  logic [ACC_W-1:0]       first_err_exp, first_err_got;
  logic [LANES*IN_W-1:0]  sa [$];
  logic [LANES*IN_W-1:0]  sb [$];
  logic [LANES-1:0]       sm [$];
  int vectors = 0, miscompares = 0;
  mac_golden_checker_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();
  mac_golden_checker #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests), .stop_on_err(stop_on_err),
    .cfg_mode(cfg_mode), .cfg_acc(cfg_acc), .init_acc(init_acc), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .checked(checked),
    .first_err_idx(first_err_idx), .first_err_lane(first_err_lane),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // group lanes into one wide number, multiply-add, then slice the result back into lanes
  function automatic logic [LANES*ACC_W-1:0] golden(input logic [1:0] mode, input bit accen,
      input logic [LANES*IN_W-1:0] av, input logic [LANES*IN_W-1:0] bv, input logic [LANES*ACC_W-1:0] cv);
    int g;
    logic [127:0] ca, cb, cc, r, mask;
    logic [LANES*ACC_W-1:0] res;
    g = (mode == 2'd3 || (1 << mode) > LANES) ? 1 : 1 << mode;
    mask = (128'd1 << (g * ACC_W)) - 128'd1;
    res = '0;
    for (int k = 0; k < LANES; k += g) begin
      ca = 0; cb = 0; cc = 0;
      for (int j = g - 1; j >= 0; j--) begin
        ca = (ca << IN_W) | 128'(av[(k+j)*IN_W +: IN_W]);
        cb = (cb << IN_W) | 128'(bv[(k+j)*IN_W +: IN_W]);
        cc = (cc << ACC_W) | 128'(cv[(k+j)*ACC_W +: ACC_W]);
      end
      r = (ca * cb + (accen ? cc : 128'd0)) & mask;
      for (int j = 0; j < g; j++) res[(k+j)*ACC_W +: ACC_W] = ACC_W'(r >> (j * ACC_W));
    end
    return res;
  endfunction
  task automatic push(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] m);
    sa.push_back(av);
    sb.push_back(bv);
    sm.push_back(m);
  endtask
  task automatic fill(input int cnt);
    for (int i = 0; i < cnt; i++) push($urandom, $urandom, 4'd0);
  endtask
  task automatic run(input string tag, input logic [1:0] mode, input bit accen, input bit stop,
      input int n, input logic [LANES*ACC_W-1:0] init, input bit bubbles);
    logic [LANES*ACC_W-1:0] pe [LATENCY+1];
    logic [LANES*ACC_W-1:0] oexp [$];
    logic [LANES*ACC_W-1:0] macc, o;
    logic [ACC_W-1:0] fe, fg;
    bit pv [LATENCY+1];
    bit failst;
    int s, cyc, f, nbad, lane, idx;
    s = 0; cyc = 0; f = -1; nbad = 0; lane = 0; macc = init;
    for (int i = 0; i <= LATENCY; i++) begin pv[i] = 0; pe[i] = '0; end
    cfg_mode = mode; cfg_acc = accen; stop_on_err = stop; num_tests = n; init_acc = init;
    start = 1'b1; bus.in_valid = 1'b0; bus.dut_out = '0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 2'($urandom); cfg_acc = 1'($urandom); stop_on_err = 1'($urandom);
    num_tests = $urandom; init_acc = {4{$urandom}};
    while (!done && cyc < 8 * sa.size() + 40) begin
      for (int i = LATENCY; i > 0; i--) begin pv[i] = pv[i-1]; pe[i] = pe[i-1]; end
      bus.in_valid = (s < sa.size()) && (!bubbles || $urandom_range(0, 3) != 0);
      pv[0] = bus.in_valid;
      if (bus.in_valid) begin
        bus.a = sa[s]; bus.b = sb[s];
        macc = golden(mode, accen, sa[s], sb[s], macc);
        pe[0] = macc;
        s++;
      end else begin
        bus.a = $urandom; bus.b = $urandom;
      end
      o = {4{$urandom}};
      if (pv[LATENCY]) begin
        o = pe[LATENCY];
        idx = oexp.size();
        for (int k = 0; k < LANES; k++)
          if (idx < sm.size() && sm[idx][k]) o[k*ACC_W +: ACC_W] = o[k*ACC_W +: ACC_W] + 1;
        oexp.push_back(pe[LATENCY]);
      end
      bus.dut_out = o;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < n && i < sm.size(); i++)
      if (sm[i] != 0) begin
        nbad++;
        if (f < 0) f = i;
      end
    fe = '0;
    if (f >= 0) begin
      for (int k = LANES - 1; k >= 0; k--) if (sm[f][k]) lane = k;
      if (f < oexp.size()) fe = oexp[f][lane*ACC_W +: ACC_W];
    end
    fg = fe + 1;
    failst = stop && f >= 0;
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " pass"}, pass, !failst && nbad == 0);
    check({tag, " checked"}, checked, failst ? f + 1 : n);
    check({tag, " err_count"}, err_count, failst ? 1 : nbad);
    check({tag, " first_idx"}, first_err_idx, f < 0 ? 0 : f);
    check({tag, " first_lane"}, first_err_lane, f < 0 ? 0 : lane);
    check({tag, " first_exp"}, first_err_exp, f < 0 ? '0 : fe);
    check({tag, " first_got"}, first_err_got, f < 0 ? '0 : fg);
    sa.delete(); sb.delete(); sm.delete();
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; stop_on_err = 1'b0; cfg_acc = 1'b0; cfg_mode = '0;
    num_tests = '0; init_acc = '0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.dut_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset checked", checked, 0);
    rst = 1'b0;
    push(32'h3, 32'h5, 4'b0001);
    run("mul", 2'd0, 1'b0, 1'b1, 1, '0, 1'b0);
    check("mul exp 15", first_err_exp, 15);
    fill(12);
    run("mul clean", 2'd0, 1'b0, 1'b0, 10, '0, 1'b0);
    check("mul clean checked", checked, 10);
    push(32'h200, 32'h300, 4'b0010); push(32'h200, 32'h300, 4'b0000);
    run("acc1", 2'd0, 1'b1, 1'b0, 2, 128'd100 << 32, 1'b0);
    check("acc exp 106", first_err_exp, 106);
    push(32'h200, 32'h300, 4'b0000); push(32'h200, 32'h300, 4'b0010);
    run("acc2", 2'd0, 1'b1, 1'b0, 2, 128'd100 << 32, 1'b0);
    check("acc exp 112", first_err_exp, 112);
    push(32'h100, 32'h2, 4'b0011);
    run("dual0", 2'd1, 1'b0, 1'b0, 1, '0, 1'b0);
    check("dual exp 512", first_err_exp, 512);
    push(32'h100, 32'h2, 4'b0010);
    run("dual1", 2'd1, 1'b0, 1'b0, 1, '0, 1'b0);
    check("dual lane1 exp 0", first_err_exp, 0);
    push(32'h0, 32'h0, 4'b0001); push(32'h1, 32'h1, 4'b0000);
    run("quad0", 2'd2, 1'b1, 1'b0, 2, '1, 1'b0);
    check("quad exp unchanged", first_err_exp, 32'hFFFF_FFFF);
    push(32'h0, 32'h0, 4'b0000); push(32'h1, 32'h1, 4'b1000);
    run("quad1", 2'd2, 1'b1, 1'b0, 2, '1, 1'b0);
    check("quad wrap exp 0", first_err_exp, 0);
    fill(3); push($urandom, $urandom, 4'b0100); fill(8);
    run("stop", 2'd0, 1'b1, 1'b1, 10, {4{$urandom}}, 1'b1);
    check("stop idx 3", first_err_idx, 3);
    check("stop lane 2", first_err_lane, 2);
    check("stop got-exp", first_err_got - first_err_exp, 1);
    for (int i = 0; i < 12; i++) push($urandom, $urandom, (i == 1) ? 4'b0001 : (i == 5) ? 4'b0010 : (i == 9) ? 4'b1000 : 4'b0000);
    run("three bad", 2'd1, 1'b1, 1'b0, 10, '0, 1'b1);
    check("three bad count", err_count, 3);
    fill(2); push($urandom, $urandom, 4'b0001);
    run("last bad", 2'd2, 1'b0, 1'b0, 3, '0, 1'b0);
    fill(2); push($urandom, $urandom, 4'b1001);
    run("last bad stop", 2'd3, 1'b1, 1'b1, 3, {4{$urandom}}, 1'b0);
    fill(1);
    run("zero tests", 2'd0, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n + 3; i++) push($urandom, $urandom, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      run($sformatf("rand%0d", r), 2'($urandom), 1'($urandom), 1'($urandom), n, {4{$urandom}}, 1'b1);
    end
    cfg_mode = 2'd0; cfg_acc = 1'b0; stop_on_err = 1'b0; num_tests = 100; init_acc = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.a = $urandom | 32'h1; bus.b = $urandom | 32'h1; bus.dut_out = '0;
      @(posedge clk); #1;
    end
    check("midrun busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst err_count", err_count, 0);
    check("rst checked", checked, 0);
    check("rst first_idx", first_err_idx, 0);
    check("rst first_lane", first_err_lane, 0);
    check("rst first_exp", first_err_exp, 0);
    check("rst first_got", first_err_got, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.dut_out = {4{$urandom}};
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("idle checked", checked, 0);
    check("idle err_count", err_count, 0);
    check("idle busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
